// File: rtl/score_frame_packer_pkg.sv
// Shared definitions for the class-score frame interface (packer, Max and their benches).
// Slot i of a packed score vector sits at bit offset slot_lsb(i).
package score_frame_packer_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 26;
  localparam int CNT_W       = 4;
  localparam int SCORE_VEC_W = NUM_CLASSES * SCORE_W;
  localparam int IDX_W       = 4;

  function automatic int slot_lsb(input int slot);
    return slot * SCORE_W;
  endfunction

endpackage

// File: rtl/score_frame_packer.sv
// Packs serial signed class scores into a flat frame vector, double-buffered so
// a new frame fills while the previous one is held for the consumer.
module score_frame_packer
  import score_frame_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [SCORE_W-1:0]     InScore,
  input  logic                   InLast,
  output logic                   FrameValid,
  input  logic                   FrameReady,
  output logic [SCORE_VEC_W-1:0] Num,
  output logic                   FrameErr,
  input  logic                   ErrClr
);

  logic [CNT_W-1:0]       r_cnt;
  logic [SCORE_VEC_W-1:0] r_fill_buf;
  logic                   r_fill_pending;
  logic [SCORE_VEC_W-1:0] r_out_buf;
  logic                   r_out_full;
  logic                   r_frame_err;

  logic                   w_accept;
  logic                   w_last_slot;
  logic                   w_complete;
  logic                   w_short;
  logic                   w_long;
  logic                   w_out_free;
  logic                   w_xfer_direct;
  logic                   w_xfer_pending;
  logic                   w_consume;
  logic [SCORE_VEC_W-1:0] w_fill_done;

  // Reset gates InReady so nothing is offered as accepted while the block is held.
  assign InReady    = !r_fill_pending && !GlobalReset;
  assign FrameValid = r_out_full;
  assign Num        = r_out_buf;
  assign FrameErr   = r_frame_err;

  assign w_accept       = InValid && InReady;
  assign w_last_slot    = (r_cnt == CNT_W'(NUM_CLASSES - 1));
  assign w_complete     = w_accept && w_last_slot;
  assign w_short        = w_accept && InLast && !w_last_slot;
  assign w_long         = w_complete && !InLast;
  assign w_out_free     = !r_out_full || FrameReady;
  assign w_xfer_direct  = w_complete && w_out_free;
  assign w_xfer_pending = r_fill_pending && w_out_free;
  assign w_consume      = r_out_full && FrameReady;

  // The final score bypasses the fill buffer so a frame can move out on its last accept.
  always_comb begin
    w_fill_done = r_fill_buf;
    w_fill_done[slot_lsb(NUM_CLASSES - 1) +: SCORE_W] = InScore;
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_cnt <= '0;
    end else if (w_short || w_complete) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_fill_buf <= '0;
    end else if (w_accept) begin
      r_fill_buf[slot_lsb(int'(r_cnt)) +: SCORE_W] <= InScore;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_fill_pending <= 1'b0;
    end else if (w_xfer_pending) begin
      r_fill_pending <= 1'b0;
    end else if (w_complete && !w_out_free) begin
      r_fill_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_xfer_direct) begin
      r_out_buf  <= w_fill_done;
      r_out_full <= 1'b1;
    end else if (w_xfer_pending) begin
      r_out_buf  <= r_fill_buf;
      r_out_full <= 1'b1;
    end else if (w_consume) begin
      r_out_full <= 1'b0;
    end
  end

  // A new framing error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_frame_err <= 1'b0;
    end else if (w_short || w_long) begin
      r_frame_err <= 1'b1;
    end else if (ErrClr) begin
      r_frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_score_frame_packer.sv
// Randomized and directed bench for score_frame_packer against a frame-queue reference model.
module tb_score_frame_packer;
  import score_frame_packer_pkg::*;

  logic                   clk;
  logic                   GlobalReset;
  logic                   InValid;
  logic                   InReady;
  logic [SCORE_W-1:0]     InScore;
  logic                   InLast;
  logic                   FrameValid;
  logic                   FrameReady;
  logic [SCORE_VEC_W-1:0] Num;
  logic                   FrameErr;
  logic                   ErrClr;

  int checks = 0;
  int errors = 0;

  // Reference model: scores of the frame being filled, and complete frames owned
  // by the packer (front = visible to consumer, second = waiting for transfer).
  logic [SCORE_W-1:0]     m_fill[$];
  logic [SCORE_VEC_W-1:0] m_held[$];
  logic [SCORE_VEC_W-1:0] m_last_num;
  logic                   m_err;

  score_frame_packer u_dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InScore     (InScore),
    .InLast      (InLast),
    .FrameValid  (FrameValid),
    .FrameReady  (FrameReady),
    .Num         (Num),
    .FrameErr    (FrameErr),
    .ErrClr      (ErrClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SCORE_VEC_W-1:0] obs,
                       input logic [SCORE_VEC_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return m_held.size() < 2;
  endfunction

  function automatic logic [SCORE_VEC_W-1:0] m_num();
    return (m_held.size() > 0) ? m_held[0] : m_last_num;
  endfunction

  task automatic model_reset();
    m_fill.delete();
    m_held.delete();
    m_last_num = '0;
    m_err      = 1'b0;
  endtask

  task automatic model_update(input logic iv, input logic [SCORE_W-1:0] sc, input logic il,
                              input logic fr, input logic ec);
    logic                   acc;
    logic                   err_set;
    logic [SCORE_VEC_W-1:0] f;
    acc     = iv && m_ready();
    err_set = 1'b0;
    if (m_held.size() > 0 && fr) begin
      m_last_num = m_held.pop_front();
    end
    if (acc) begin
      m_fill.push_back(sc);
      if (il && m_fill.size() < NUM_CLASSES) begin
        err_set = 1'b1;
        m_fill.delete();
      end else if (m_fill.size() == NUM_CLASSES) begin
        f = '0;
        for (int k = 0; k < NUM_CLASSES; k++) f[k*SCORE_W +: SCORE_W] = m_fill[k];
        m_held.push_back(f);
        if (!il) err_set = 1'b1;
        m_fill.delete();
      end
    end
    if (err_set) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
  endtask

  task automatic compare_all();
    check("in_ready", InReady, m_ready());
    check("frame_valid", FrameValid, m_held.size() > 0);
    check("num", Num, m_num());
    check("frame_err", FrameErr, m_err);
  endtask

  task automatic step(input logic iv, input logic [SCORE_W-1:0] sc, input logic il,
                      input logic fr, input logic ec);
    InValid    = iv;
    InScore    = sc;
    InLast     = il;
    FrameReady = fr;
    ErrClr     = ec;
    model_update(iv, sc, il, fr, ec);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic fr);
    step(1'b0, '0, 1'b0, fr, 1'b0);
  endtask

  task automatic do_reset();
    GlobalReset = 1'b1;
    InValid = 1'b0; InScore = '0; InLast = 1'b0; FrameReady = 1'b0; ErrClr = 1'b0;
    #1;
    check("rst_in_ready", InReady, 1'b0);
    check("rst_frame_valid", FrameValid, 1'b0);
    check("rst_num", Num, '0);
    check("rst_frame_err", FrameErr, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_valid", FrameValid, 1'b0);
    check("rst_hold_num", Num, '0);
    model_reset();
    GlobalReset = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic fr);
    for (int k = 0; k < NUM_CLASSES; k++)
      step(1'b1, SCORE_W'($urandom), k == NUM_CLASSES - 1, fr, 1'b0);
  endtask

  int plan_vals [NUM_CLASSES] = '{-10, -15, -2, -100, -30, -10000, 200, -301234, -10000, -69};

  initial begin
    int best;
    logic [SCORE_W-1:0] s;
    logic iv, il, fr, ec;
    model_reset();
    GlobalReset = 1'b1;
    InValid = 1'b0; InScore = '0; InLast = 1'b0; FrameReady = 1'b0; ErrClr = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Known frame: the maximum score sits in slot 6.
    for (int k = 0; k < NUM_CLASSES; k++) begin
      s = SCORE_W'(plan_vals[k]);
      step(1'b1, s, k == NUM_CLASSES - 1, 1'b1, 1'b0);
    end
    check("plan_valid", FrameValid, 1'b1);
    check("plan_slot6", Num[6*SCORE_W +: SCORE_W], 26'd200);
    check("plan_slot7", Num[7*SCORE_W +: SCORE_W], 26'h3FB674E);
    best = 0;
    for (int k = 1; k < NUM_CLASSES; k++)
      if ($signed(Num[k*SCORE_W +: SCORE_W]) > $signed(Num[best*SCORE_W +: SCORE_W])) best = k;
    check("plan_argmax", IDX_W'(best), IDX_W'(6));
    idle(1'b1);

    // Two frames held off by the consumer, then released one at a time.
    send_frame(1'b0);
    send_frame(1'b0);
    repeat (3) idle(1'b0);
    check("bp_in_ready_low", InReady, 1'b0);
    idle(1'b1);
    check("bp_valid_kept", FrameValid, 1'b1);
    check("bp_in_ready_back", InReady, 1'b1);
    idle(1'b1);

    // Continuous stream with the consumer always ready.
    repeat (3) send_frame(1'b1);
    idle(1'b1);

    // Short frame, clean recovery, then clear.
    for (int k = 0; k < 4; k++) step(1'b1, SCORE_W'($urandom), k == 3, 1'b1, 1'b0);
    check("short_err", FrameErr, 1'b1);
    send_frame(1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("short_cleared", FrameErr, 1'b0);

    // Reset in the middle of a frame.
    for (int k = 0; k < 5; k++) step(1'b1, SCORE_W'($urandom), 1'b0, 1'b0, 1'b0);
    do_reset();
    send_frame(1'b0);
    idle(1'b1);

    // Long frame, then a clear colliding with a new short-frame error.
    for (int k = 0; k < NUM_CLASSES; k++) step(1'b1, SCORE_W'($urandom), 1'b0, 1'b1, 1'b0);
    check("long_err", FrameErr, 1'b1);
    step(1'b1, SCORE_W'($urandom), 1'b0, 1'b1, 1'b0);
    step(1'b1, SCORE_W'($urandom), 1'b1, 1'b1, 1'b1);
    check("clr_vs_err", FrameErr, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Random traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      iv = ($urandom % 4) != 0;
      if (m_fill.size() == NUM_CLASSES - 1) il = ($urandom % 16) != 0;
      else il = ($urandom % 32) == 0;
      case ((i / 500) % 3)
        0:       fr = 1'b1;
        1:       fr = ($urandom % 2) == 0;
        default: fr = ($urandom % 8) == 0;
      endcase
      ec = ($urandom % 64) == 0;
      if (($urandom % 700) == 0) do_reset();
      else step(iv, SCORE_W'($urandom), il, fr, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
